// File: rtl/dual_pixel_feeder.sv
// Split-screen pixel source for the HDMI timing driver: two camera FIFOs,
// left half of each line from channel 0 and right half from channel 1.
module dual_pixel_feeder #(
  parameter int          H_DISP     = 1280,
  parameter int          ADDR_W     = 10,
  parameter int          AFULL_TH   = 768,
  parameter logic [15:0] FILL_COLOR = 16'h0000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_vs,
  input  logic        data_req,
  output logic [15:0] pixel_data,
  input  logic        wr_en0,
  input  logic [15:0] wr_data0,
  input  logic        wr_en1,
  input  logic [15:0] wr_data1,
  output logic        afull0,
  output logic        afull1,
  output logic        frame_start,
  output logic [1:0]  underflow,
  output logic [1:0]  overflow,
  input  logic        err_clr
);

  localparam logic [10:0]     HALF      = 11'(H_DISP / 2);
  localparam logic [10:0]     LAST      = 11'(H_DISP - 1);
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W + 1)'(1);

  logic        vs_q;
  logic        flush;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic        sel1;
  logic [1:0]  rd_req, wr_req, uf_set, of_set, afull_w;
  logic [1:0][15:0] wr_data, rd_data;
  logic        req1_q, sel1_q, uf1_q, fs_q;
  logic [15:0] pixel_q;
  logic [1:0]  uf_q, of_q;

  // Falling edge of vsync flushes both FIFOs in the same cycle.
  assign flush   = vs_q & ~video_vs;
  assign sel1    = (pix_cnt_q >= HALF);
  assign rd_req  = {data_req & sel1, data_req & ~sel1};
  assign wr_req  = {wr_en1, wr_en0};
  assign wr_data = {wr_data1, wr_data0};

  always_comb begin
    pix_cnt_d = 11'd0;
    if (data_req) begin
      pix_cnt_d = (pix_cnt_q == LAST) ? pix_cnt_q : pix_cnt_q + 11'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [15:0]       mem [1 << ADDR_W];
      logic [15:0]       rd_data_q;
      logic [ADDR_W-1:0] wptr_q, rptr_q;
      logic [ADDR_W:0]   level_q, level_d;
      logic              afull_q;
      logic              empty, full, rd_ok, wr_ok;

      assign empty = (level_q == '0);
      assign full  = level_q[ADDR_W];
      // A read on empty never sees a same-cycle write.
      assign rd_ok = rd_req[gi] & ~empty;
      assign wr_ok = wr_req[gi] & ~flush & (~full | rd_ok);
      assign uf_set[gi]  = rd_req[gi] & empty;
      assign of_set[gi]  = wr_req[gi] & ~flush & full & ~rd_ok;
      assign rd_data[gi] = rd_data_q;
      assign afull_w[gi] = afull_q;

      always_comb begin
        level_d = level_q;
        if (wr_ok && !rd_ok) level_d = level_q + LVL_ONE;
        else if (rd_ok && !wr_ok) level_d = level_q - LVL_ONE;
      end

      always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          level_q <= '0;
          afull_q <= 1'b0;
        end else begin
          afull_q <= (level_q >= AFULL_LVL);
          if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
          end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
          end
        end
      end

      always_ff @(posedge pixel_clk) begin
        if (wr_ok) mem[wptr_q] <= wr_data[gi];
        if (rd_ok) rd_data_q <= mem[rptr_q];
      end
    end
  endgenerate

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q      <= 1'b1;
      pix_cnt_q <= '0;
      req1_q    <= 1'b0;
      sel1_q    <= 1'b0;
      uf1_q     <= 1'b0;
      pixel_q   <= '0;
      fs_q      <= 1'b0;
      uf_q      <= '0;
      of_q      <= '0;
    end else begin
      vs_q      <= video_vs;
      pix_cnt_q <= pix_cnt_d;
      req1_q    <= data_req;
      sel1_q    <= sel1;
      uf1_q     <= |uf_set;
      fs_q      <= flush;
      // Second stage: RAM output lands here, or fill colour on underflow.
      if (req1_q) pixel_q <= uf1_q ? FILL_COLOR : rd_data[sel1_q];
      // Set has priority over a same-cycle clear.
      uf_q <= (err_clr ? 2'b00 : uf_q) | uf_set;
      of_q <= (err_clr ? 2'b00 : of_q) | of_set;
    end
  end

  assign pixel_data  = pixel_q;
  assign afull0      = afull_w[0];
  assign afull1      = afull_w[1];
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign overflow    = of_q;

endmodule

// File: tb/tb_dual_pixel_feeder.sv
// Bench for dual_pixel_feeder: queue model of both FIFOs feeds a pixel
// scoreboard; flags are checked against fixed expectations.
module tb_dual_pixel_feeder;

  localparam logic [15:0] FILL = 16'h0000;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n, video_vs, data_req, err_clr;
  logic        wr_en0, wr_en1;
  logic [15:0] wr_data0, wr_data1, pixel_data;
  logic        afull0, afull1, frame_start;
  logic [1:0]  underflow, overflow;

  dual_pixel_feeder dut (
    .pixel_clk  (pixel_clk),
    .sys_rst_n  (sys_rst_n),
    .video_vs   (video_vs),
    .data_req   (data_req),
    .pixel_data (pixel_data),
    .wr_en0     (wr_en0),
    .wr_data0   (wr_data0),
    .wr_en1     (wr_en1),
    .wr_data1   (wr_data1),
    .afull0     (afull0),
    .afull1     (afull1),
    .frame_start(frame_start),
    .underflow  (underflow),
    .overflow   (overflow),
    .err_clr    (err_clr)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sb_q[$];
  logic [15:0] m0[$], m1[$];
  int          m_cnt = 0;
  logic        m_vs  = 1'b1;

  typedef struct {
    logic       req;
    logic       clr;
    logic [1:0] uf;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model.
  task automatic step(input logic w0, input logic [15:0] d0, input logic w1,
                      input logic [15:0] d1, input logic req, input logic clr,
                      input logic vs);
    logic fl;
    @(negedge pixel_clk);
    wr_en0 = w0; wr_data0 = d0; wr_en1 = w1; wr_data1 = d1;
    data_req = req; err_clr = clr; video_vs = vs;
    fl = m_vs & ~vs;
    if (req) begin
      if (m_cnt < 640) begin
        if (m0.size() > 0) sb_q.push_back(m0.pop_front());
        else sb_q.push_back(FILL);
      end else begin
        if (m1.size() > 0) sb_q.push_back(m1.pop_front());
        else sb_q.push_back(FILL);
      end
      if (m_cnt != 1279) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    if (w0 && !fl && m0.size() < 1024) m0.push_back(d0);
    if (w1 && !fl && m1.size() < 1024) m1.push_back(d1);
    if (fl) begin
      m0.delete();
      m1.delete();
    end
    m_vs = vs;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, vs);
  endtask

  task automatic settle();
    @(posedge pixel_clk);
    #1;
  endtask

  // Output monitor: a request seen at one edge is due after the next edge.
  logic cur_req, prev_req = 1'b0;
  always begin
    @(posedge pixel_clk);
    cur_req = data_req;
    #1;
    if (!sys_rst_n) begin
      prev_req = 1'b0;
      sb_q.delete();
    end else begin
      if (prev_req) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel: unexpected output %0h with empty scoreboard", pixel_data);
        end else begin
          check("pixel", {16'h0, pixel_data}, {16'h0, sb_q.pop_front()});
        end
      end
      prev_req = cur_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{req: 1'b0, clr: 1'b1, uf: 2'b00};
    tbl[1] = '{req: 1'b1, clr: 1'b0, uf: 2'b01};
    tbl[2] = '{req: 1'b1, clr: 1'b1, uf: 2'b01};
    tbl[3] = '{req: 1'b0, clr: 1'b1, uf: 2'b00};
    tbl[4] = '{req: 1'b0, clr: 1'b0, uf: 2'b00};

    sys_rst_n = 1'b0; video_vs = 1'b1; data_req = 1'b0; err_clr = 1'b0;
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_pixel", pixel_data, 0);
    check("rst_afull0", afull0, 0);
    check("rst_afull1", afull1, 0);
    check("rst_fs", frame_start, 0);
    check("rst_uf", underflow, 0);
    check("rst_of", overflow, 0);
    @(negedge pixel_clk);
    sys_rst_n = 1'b1;

    // Full line, both halves populated
    for (int i = 0; i < 640; i++)
      step(1'b1, 16'(i + 1), 1'b1, 16'(16'h8001 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1280; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("line_uf", underflow, 0);
    check("line_of", overflow, 0);

    // Underflow on channel 0 after three pixels
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0A01 + i), 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 640; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("uf_set", underflow, 2'b01);
    idle(5, 1'b1);
    check("uf_sticky", underflow, 2'b01);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 16'h0, 1'b0, 16'h0, tbl[k].req, tbl[k].clr, 1'b1);
      settle();
      check($sformatf("uf_tbl%0d", k), underflow, tbl[k].uf);
    end

    // Overflow on channel 1
    for (int i = 0; i < 1024; i++) step(1'b0, 16'h0, 1'b1, 16'(16'hC000 + i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("of_none_at_1024", overflow, 0);
    check("afull1_full", afull1, 1);
    step(1'b0, 16'h0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    settle();
    check("of_1025th", overflow, 2'b10);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    settle();
    check("of_clr", overflow, 0);
    for (int i = 0; i < 640; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    settle();
    check("of_rw_full", overflow, 0);
    check("uf_left_half", underflow, 2'b01);
    step(1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    settle();
    check("of_still_full", overflow, 2'b10);

    // Almost-full threshold on channel 0
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 767; i++) step(1'b1, 16'(16'h4000 + i), 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("afull0_767", afull0, 0);
    step(1'b1, 16'h4300, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    settle();
    check("afull0_lag", afull0, 0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    settle();
    check("afull0_768", afull0, 1);

    // Frame start flushes both FIFOs
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    settle();
    check("fs_pulse_a", frame_start, 1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    settle();
    check("fs_low_a", frame_start, 0);
    for (int i = 0; i < 100; i++)
      step(1'b1, 16'(16'h5000 + i), 1'b1, 16'(16'h6000 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 1'b1, 16'h7778, 1'b0, 1'b0, 1'b0);
    settle();
    check("fs_pulse_b", frame_start, 1);
    check("fs_no_of", overflow, 0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    settle();
    check("fs_one_cycle", frame_start, 0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    settle();
    check("fs_ch0_empty", underflow, 2'b01);
    idle(3, 1'b1);
    check("fs_afull0_clr", afull0, 0);
    check("fs_afull1_clr", afull1, 0);

    // Asynchronous reset in the middle of a burst
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) step(1'b1, 16'(16'h9000 + i), 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    @(negedge pixel_clk);
    data_req = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_pixel", pixel_data, 0);
    check("mid_rst_afull0", afull0, 0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_uf", underflow, 0);
    check("mid_rst_of", overflow, 0);
    m0.delete();
    m1.delete();
    m_cnt = 0;
    m_vs = 1'b1;
    repeat (2) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    settle();
    check("post_rst_uf", underflow, 2'b01);
    idle(3, 1'b1);
    check("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_pixel_feeder.md
Name: dual_pixel_feeder

Overview:
- Sits directly upstream of the HDMI video timing driver and answers its per-pixel `data_req` with RGB565 `pixel_data`.
- Holds two synchronous pixel FIFOs, one per camera channel, filled by the frame-buffer read paths.
- Serves a side-by-side split screen: the left half of each line comes from channel 0, the right half from channel 1.
- Generates a frame-start pulse for the upstream readers and flags underflow/overflow.

Parameters:
- H_DISP, 1280, active pixels per line; must be even.
- ADDR_W, 10, FIFO address width; depth = 2^ADDR_W.
- AFULL_TH, 768, fill level at or above which `afull` asserts.
- FILL_COLOR, 16'h0000, pixel emitted on underflow.

Ports:
- pixel_clk  in  1  pixel clock; all logic is on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- video_vs  in  1  vertical sync from the timing driver, active low.
- data_req  in  1  pixel request from the timing driver; one pixel per high cycle.
- pixel_data  out  16  RGB565 pixel to the timing driver.
- wr_en0  in  1  channel 0 FIFO write strobe.
- wr_data0  in  16  channel 0 write pixel.
- wr_en1  in  1  channel 1 FIFO write strobe.
- wr_data1  in  16  channel 1 write pixel.
- afull0  out  1  channel 0 fill level >= AFULL_TH.
- afull1  out  1  channel 1 fill level >= AFULL_TH.
- frame_start  out  1  one-cycle pulse at start of frame.
- underflow  out  2  sticky; bit n = channel n read while empty.
- overflow  out  2  sticky; bit n = channel n write while full.
- err_clr  in  1  synchronous clear of underflow and overflow.

Behaviour:

Reset (async, sys_rst_n low):
- `pixel_data`=0, `afull0`/`afull1`=0, `frame_start`=0, `underflow`=0, `overflow`=0.
- FIFO pointers and levels cleared; pixel counter cleared; `video_vs` history register set to 1.
- Reset mid-line discards FIFO contents; the next pixel after release is FILL_COLOR until a channel is written.

FIFOs:
- Each channel has a level counter of width ADDR_W+1.
- A write is accepted when level < 2^ADDR_W, or when the same channel is read in the same cycle.
- Otherwise the write is dropped and `overflow[n]` is set.
- Read on empty never bypasses a same-cycle write: it counts as underflow, `underflow[n]` is set, and the pointers do not move.
- Level updates +1 on write only, -1 on read only, unchanged on write and read together.
- `afull` is registered from the level, so it lags the level by one cycle.

Channel select:
- `pix_cnt` (11 bit) increments on every `data_req`-high cycle and clears to 0 on any cycle with `data_req` low.
- A request reads channel 0 if `pix_cnt` < H_DISP/2, otherwise channel 1.
- If `pix_cnt` reaches H_DISP-1 it saturates, and further requests read channel 1.

Latency:
- A request sampled high at cycle t yields its pixel on `pixel_data` at t+2: t+1 is the FIFO RAM registered output, t+2 is the output register.
- This matches the timing driver's two-stage delay from `data_req` to its data-enable.
- The output register holds FILL_COLOR at t+2 when the request at t underflowed.
- On cycles with no request, `pixel_data` holds its last value; the timing driver masks it.

Frame start:
- Triggered by a falling edge of `video_vs` (registered history 1, current 0).
- In that cycle `frame_start`=1 for exactly one cycle and both FIFOs flush (pointers and levels to 0).
- Writes in the flush cycle are dropped without setting `overflow`; an in-flight output pixel still completes.
- Upstream readers restart their frame on `frame_start`.

Error flags:
- `err_clr` clears the flags in the cycle it is high.
- If a set event occurs in the same cycle as `err_clr`, set wins.

Test Plan:
- Reset release, then write 640 pixels 0x0001..0x0280 to ch0 and 640 pixels 0x8001..0x8280 to ch1, then a 1280-cycle `data_req` burst at t0 -> `pixel_data` is 0x0001 at t0+2, 0x0280 at t0+641, 0x8001 at t0+642, 0x8280 at t0+1281; no flags set.
- Ch0 holds 3 pixels, 640-cycle burst -> 3 valid pixels, then 0x0000 (FILL_COLOR) from t0+5; `underflow`=2'b01 sticky until `err_clr`, and stays set when a new underflow coincides with `err_clr`.
- Write 1024 pixels to ch1, then a 1025th write -> dropped, `overflow`=2'b10. A simultaneous write and ch1 read while full -> accepted, level stays 1024.
- Fill ch0 to 767 -> `afull0`=0; 768th write -> `afull0`=1 one cycle after the write cycle.
- `video_vs` 1->0 with both FIFOs at level 100 and a write in the same cycle -> `frame_start` pulses for 1 cycle, both levels read 0 next cycle, `overflow` stays 0.
- `sys_rst_n` asserted mid-burst at pixel 300 -> all outputs 0 immediately; after release, the first request returns FILL_COLOR and sets `underflow[0]`.
